caravel_counter: RTL and testbench



---
 rtl/caravel_counter_if.sv | 10 +
 rtl/caravel_counter.sv | 146 ++++++++++++++
 tb/tb_caravel_counter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/caravel_counter_if.sv
// Pad bank between the management SoC and the counter payload.
// Carries pad inputs, pad outputs and their active-low output enables.
interface caravel_counter_if;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    modport master (output io_in, input io_out, input io_oeb);
    modport slave  (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/caravel_counter.sv
// Two-digit 7-seg counter with shadow self-check and stage FSM; COUNTER_DOWN_EN adds io_in[1] down-count.
// Latency: tick registered, BCD/shadow/stage update the cycle after tick; seg shares the digit-select register stage.
// Backpressure: none; io_in[0] hold freezes the prescaler only.
module caravel_counter #(
    parameter int PRESCALE = 40,
    parameter int MUX_DIV  = 8
) (
    input  logic              clock,
    input  logic              resetb,
    caravel_counter_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

    typedef enum logic [4:0] {
        ST_RESET = 5'd0,
        ST_PASS  = 5'd30,
        ST_RUN   = 5'd31
    } stage_t;

    logic [PW-1:0] pre_q;
    logic          tick_q;
    logic [3:0]    ones_q, tens_q;
    logic [6:0]    shadow_q;
    logic [MW-1:0] mux_q;
    logic          sel_q;
    logic [6:0]    seg_q;
    stage_t        stage_q;
    logic          error_q;

    logic hold;
    logic down;
    logic unused_in;
    assign hold = bus.io_in[0];
`ifdef COUNTER_DOWN_EN
    assign down      = bus.io_in[1];
    assign unused_in = ^bus.io_in[37:2];
`else
    assign down      = 1'b0;
    assign unused_in = ^bus.io_in[37:1];
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    logic [7:0] bin;
    assign bin = {1'b0, tens_q, 3'b000} + {3'b000, tens_q, 1'b0} + {4'b0000, ones_q};

    logic [3:0] ones_d, tens_d;
    logic [6:0] shadow_d;
    logic       wrap;
    logic       sel_d;
    logic       pre_end;
    logic       mux_end;

    assign pre_end = (pre_q == PW'(PRESCALE - 1));
    assign mux_end = (mux_q == MW'(MUX_DIV - 1));
    assign sel_d   = mux_end ? ~sel_q : sel_q;

    always_comb begin
        ones_d   = ones_q;
        tens_d   = tens_q;
        shadow_d = shadow_q;
        wrap     = 1'b0;
        if (tick_q) begin
            if (down) begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    if (tens_q == 4'd0) begin
                        tens_d = 4'd9;
                        wrap   = 1'b1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
                shadow_d = (shadow_q == 7'd0) ? 7'd99 : shadow_q - 7'd1;
            end else begin
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    if (tens_q == 4'd9) begin
                        tens_d = 4'd0;
                        wrap   = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    ones_d = ones_q + 4'd1;
                end
                shadow_d = (shadow_q == 7'd99) ? 7'd0 : shadow_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            pre_q    <= '0;
            tick_q   <= 1'b0;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            shadow_q <= 7'd0;
            mux_q    <= '0;
            sel_q    <= 1'b0;
            seg_q    <= 7'h3F;
            stage_q  <= ST_RESET;
            error_q  <= 1'b0;
        end else begin
            if (!hold) begin
                pre_q  <= pre_end ? '0 : pre_q + PW'(1);
                tick_q <= pre_end;
            end else begin
                tick_q <= 1'b0;
            end
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            shadow_q <= shadow_d;
            mux_q    <= mux_end ? '0 : mux_q + MW'(1);
            sel_q    <= sel_d;
            // Decode the next-state digit so seg always matches the current select and count.
            seg_q    <= seg_decode(sel_d ? tens_d : ones_d);
            error_q  <= error_q | ({1'b0, shadow_q} != bin);
            case (stage_q)
                ST_RESET: stage_q <= ST_RUN;
                ST_RUN:   if (wrap && !error_q) stage_q <= ST_PASS;
                default:  stage_q <= stage_q;
            endcase
        end
    end

    assign bus.io_out = {error_q, stage_q, 7'b0, tick_q, bin, sel_q, seg_q, 8'b0};
    assign bus.io_oeb = {30'b0, 8'hFF};
endmodule

// File: tb/tb_caravel_counter.sv
// Randomized bench for caravel_counter against a cycle-count arithmetic model.
module tb_caravel_counter;
    localparam int P = 40;
    localparam int M = 8;
`ifdef COUNTER_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    caravel_counter_if bus();

    caravel_counter #(.PRESCALE(P), .MUX_DIV(M)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: count from ticks, tick from active-cycle count, select from total cycles.
    int m_cnt, m_act, m_cyc, m_stage;
    bit m_tick, m_err;

    task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    function automatic logic [37:0] exp_out();
        logic       sel;
        logic [6:0] seg;
        logic [4:0] st;
        logic [7:0] c;
        sel = ((m_cyc / M) % 2) == 1;
        seg = seg_of(sel ? m_cnt / 10 : m_cnt % 10);
        st  = 5'(m_stage);
        c   = 8'(m_cnt);
        return {m_err, st, 7'b0, m_tick, c, sel, seg, 8'b0};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_act = 0; m_cyc = 0; m_stage = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_step(input bit h, input bit dn);
        bit wrapped;
        wrapped = 1'b0;
        if (m_tick) begin
            if (dn) begin
                wrapped = (m_cnt == 0);
                m_cnt = (m_cnt + 99) % 100;
            end else begin
                wrapped = (m_cnt == 99);
                m_cnt = (m_cnt + 1) % 100;
            end
        end
        if (m_stage == 0) m_stage = 31;
        else if (m_stage == 31 && wrapped && !m_err) m_stage = 30;
        if (!h) begin
            m_act++;
            m_tick = (m_act % P) == 0;
        end else begin
            m_tick = 1'b0;
        end
        m_cyc++;
    endtask

    // Entered and left at a negedge; inputs change only there.
    task automatic step(input bit h, input bit dn, input bit do_chk, input string tag);
        bus.io_in = {36'b0, dn, h};
        @(posedge clock);
        model_step(h, dn & DOWN_EN);
        @(negedge clock);
        if (do_chk) check(tag, bus.io_out, exp_out());
    endtask

    initial begin
        bit h;
        int len;
        bus.io_in = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_out", bus.io_out, exp_out());
        check("rst_oeb", bus.io_oeb, 38'h00000000FF);

        resetb = 1'b1;
        step(0, 0, 1, "first");
        check("stage_run", 38'(bus.io_out[36:32]), 38'd31);

        for (int i = 0; i < 4100; i++) step(0, 0, 1, "up");
        check("stage_pass", 38'(bus.io_out[36:32]), 38'd30);
        check("no_err", 38'(bus.io_out[37]), 38'd0);

        for (int i = 0; i < 4000 && m_cnt != 37; i++) step(0, 0, 1, "seek37");
        for (int i = 0; i < 200; i++) step(1, 0, 1, "hold");
        check("hold_cnt", 38'(bus.io_out[23:16]), 38'd37);

        for (int b = 0; b < 60; b++) begin
            h   = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) step(h, 0, 1, "rand");
        end

`ifdef COUNTER_DOWN_EN
        resetb = 1'b0;
        model_reset();
        bus.io_in = 38'd2;
        @(negedge clock);
        resetb = 1'b1;
        for (int i = 0; i < 45; i++) step(0, 1, 1, "down");
        check("down_cnt", 38'(bus.io_out[23:16]), 38'd99);
        check("down_pass", 38'(bus.io_out[36:32]), 38'd30);
        for (int i = 0; i < 600; i++) step(0, $urandom_range(0, 1), 1, "updown");
`endif

        force dut.tens_q = 4'd12;
        step(0, 0, 0, "");
        check("err_set", 38'(bus.io_out[37]), 38'd1);
        step(0, 0, 0, "");
        release dut.tens_q;
        for (int i = 0; i < 20; i++) step(0, 0, 0, "");
        check("err_sticky", 38'(bus.io_out[37]), 38'd1);

        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        check("async_rst", bus.io_out, 38'h0000003F00);
        check("async_oeb", bus.io_oeb, 38'h00000000FF);
        @(negedge clock);
        resetb = 1'b1;
        step(0, 0, 1, "rerun");
        check("restage", 38'(bus.io_out[36:32]), 38'd31);
        for (int i = 0; i < 300; i++) step(0, 0, 1, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
